// File: rtl/matmul_pkg.sv
// Shared types for the matmul APB requester: bus widths, the command and
// response bundles carried through its FIFOs, and the requester FSM states.
package matmul_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_DIM    = 4;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [MAX_DIM-1:0]    strb;
  } apb_cmd_t;

  typedef struct packed {
    logic                 write;
    logic [BUS_WIDTH-1:0] rdata;
    logic                 err;
    logic                 timeout;
  } apb_rsp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_e;

endpackage

// File: rtl/matmul_sync_fifo.sv
// First-word-fall-through synchronous FIFO, async active-high reset.
// Ports: clk, rst, push/wdata, pop/rdata, full, empty, count.
module matmul_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/matmul_apb_master.sv
// APB4 requester: queued register commands in, APB transfers out, one
// response (rdata/err/timeout) per transfer. Ports: cmd_* in, rsp_* out,
// p* APB bus, idle_o.
module matmul_apb_master
  import matmul_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_write_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  output logic                  idle_o
);

  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int RW = $clog2(RSP_DEPTH) + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RSP_LAST = RW'(RSP_DEPTH - 1);

  apb_cmd_t       cmd_in;
  apb_cmd_t       cmd_head;
  apb_rsp_t       rsp_in;
  apb_rsp_t       rsp_head;
  apb_mst_state_e state;
  logic [TW-1:0]  tcnt;
  logic [CW-1:0]  cmd_count;
  logic [RW-1:0]  rsp_count;
  logic           cmd_full;
  logic           cmd_empty;
  logic           cmd_pop;
  logic           rsp_full;
  logic           rsp_empty;
  logic           rsp_push;
  logic           rsp_pop;
  logic           done;
  logic           expired;
  logic           issue_idle;
  logic           issue_b2b;

  assign cmd_in = '{write: cmd_write_i, addr: cmd_addr_i,
                    wdata: cmd_wdata_i, strb: cmd_strb_i};

  matmul_sync_fifo #(.WIDTH($bits(apb_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (cmd_valid_i && !cmd_full),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  matmul_sync_fifo #(.WIDTH($bits(apb_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (rsp_push),
    .wdata (rsp_in),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  assign cmd_ready_o   = !cmd_full;
  assign rsp_valid_o   = !rsp_empty;
  assign rsp_write_o   = rsp_head.write;
  assign rsp_rdata_o   = rsp_head.rdata;
  assign rsp_err_o     = rsp_head.err;
  assign rsp_timeout_o = rsp_head.timeout;
  assign idle_o = (cmd_count == '0) && rsp_empty && (state == IDLE);

  assign done    = (state == ACCESS) && pready_i;
  assign expired = (TIMEOUT_CYCLES != 0) && (state == ACCESS)
                   && !pready_i && (tcnt == T_LAST);
  assign rsp_pop = rsp_ready_i && !rsp_empty;

  // Back-to-back issue happens while the current response is being pushed,
  // so that response's slot must be counted too.
  assign issue_idle = !cmd_empty && !rsp_full;
  assign issue_b2b  = !cmd_empty && ((rsp_count < RSP_LAST) || rsp_pop);
  assign cmd_pop    = ((state == IDLE) && issue_idle) || (done && issue_b2b);
  assign rsp_push   = done || expired;

  always_comb begin
    rsp_in       = '0;
    rsp_in.write = pwrite_o;
    if (done) begin
      if (!pwrite_o) rsp_in.rdata = prdata_i;
      rsp_in.err = pslverr_i;
    end else begin
      rsp_in.err     = 1'b1;
      rsp_in.timeout = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else if (cmd_pop) begin
      pwrite_o <= cmd_head.write;
      paddr_o  <= cmd_head.addr;
      pwdata_o <= cmd_head.write ? cmd_head.wdata : '0;
      pstrb_o  <= cmd_head.write ? cmd_head.strb : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tcnt      <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_idle) begin
            state  <= SETUP;
            psel_o <= 1'b1;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
          tcnt      <= '0;
        end
        ACCESS: begin
          if (done) begin
            penable_o <= 1'b0;
            if (issue_b2b) begin
              state <= SETUP;
            end else begin
              state  <= IDLE;
              psel_o <= 1'b0;
            end
          end else if (expired) begin
            state     <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
          end else if (TIMEOUT_CYCLES != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_apb_master.sv
// Self-checking bench for matmul_apb_master with a scripted APB slave,
// response/transfer scoreboards and per-scenario checks.
module tb_matmul_apb_master;
  import matmul_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [BUS_WIDTH-1:0]  cmd_wdata_i;
  logic [MAX_DIM-1:0]    cmd_strb_i;
  logic                  rsp_valid_o, rsp_ready_i, rsp_write_o;
  logic [BUS_WIDTH-1:0]  rsp_rdata_o;
  logic                  rsp_err_o, rsp_timeout_o;
  logic                  psel_o, penable_o, pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [BUS_WIDTH-1:0]  pwdata_o;
  logic [MAX_DIM-1:0]    pstrb_o;
  logic [BUS_WIDTH-1:0]  prdata_i;
  logic                  pready_i, pslverr_i, idle_o;

  matmul_apb_master #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_write_o(rsp_write_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  apb_rsp_t exp_q[$];
  apb_cmd_t xq[$];
  apb_cmd_t mon_q[$];

  int          ws = 0;
  bit          hang = 0;
  bit          err_val = 0;
  logic [31:0] rd_val = 32'h5555_AAAA;
  int          wcnt = 0;
  int          mon_cnt = 0;
  int          psel_rises = 0;
  logic        psel_d = 1'b0;

  // Slave model plus transfer monitor, both on the falling edge.
  always @(negedge clk) begin
    if (psel_o && penable_o) begin
      pready_i = !hang && (wcnt >= ws);
      wcnt++;
    end else begin
      pready_i = 1'b0;
      wcnt = 0;
    end
    prdata_i  = pready_i ? rd_val : 32'hA5A5_A5A5;
    pslverr_i = pready_i && err_val;
    if (psel_o && penable_o && pready_i) begin
      mon_q.push_back({pwrite_o, paddr_o, pwdata_o, pstrb_o});
      mon_cnt++;
    end
    if (psel_o && !psel_d) psel_rises++;
    psel_d = psel_o;
  end

  task automatic exp_rsp(input logic w, input logic [31:0] r,
                         input logic e, input logic t);
    apb_rsp_t x;
    x.write = w; x.rdata = r; x.err = e; x.timeout = t;
    exp_q.push_back(x);
  endtask

  task automatic exp_xfer(input logic w, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    apb_cmd_t x;
    x.write = w; x.addr = a;
    x.wdata = w ? d : 32'h0;
    x.strb  = w ? s : 4'h0;
    xq.push_back(x);
  endtask

  task automatic push_cmd(input logic w, input logic [15:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_write_i = w;
    cmd_addr_i = a; cmd_wdata_i = d; cmd_strb_i = s;
    while (!cmd_ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      fails++;
      $display("FAIL cmd_accept ready=%0b required 1", cmd_ready_o);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic pop_rsp();
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o} !== '0) begin
      fails++;
      $display("FAIL reset_apb psel=%0b pen=%0b addr=%h required all 0",
               psel_o, penable_o, paddr_o);
    end
    checks++;
    if ({cmd_ready_o, idle_o, rsp_valid_o} !== 3'b110) begin
      fails++;
      $display("FAIL reset_flags rdy/idle/rv=%b required 110",
               {cmd_ready_o, idle_o, rsp_valid_o});
    end
    checks++;
    if ({rsp_write_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== '0) begin
      fails++;
      $display("FAIL reset_rsp rdata=%h err=%0b required 0",
               rsp_rdata_o, rsp_err_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    apb_rsp_t e, got;
    bit ok;
    exp_xfer(1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF);
    exp_rsp(1'b1, 32'h0, 1'b0, 1'b0);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 16'h0010;
    cmd_wdata_i = 32'hDEAD_BEEF; cmd_strb_i = 4'hF;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    checks++;
    if (psel_o !== 1'b0) begin
      fails++; $display("FAIL sw_t0 psel=%0b required 0", psel_o);
    end
    @(posedge clk); #1;
    checks++;
    if ({psel_o, penable_o} !== 2'b10) begin
      fails++; $display("FAIL sw_setup psel/pen=%b required 10", {psel_o, penable_o});
    end
    @(posedge clk); #1;
    checks++;
    if ({psel_o, penable_o} !== 2'b11) begin
      fails++; $display("FAIL sw_access psel/pen=%b required 11", {psel_o, penable_o});
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid_o, psel_o, penable_o} !== 3'b100) begin
      fails++;
      $display("FAIL sw_t3 rv/psel/pen=%b required 100", {rsp_valid_o, psel_o, penable_o});
    end
    wait_rsp(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      fails++; $display("FAIL sw_rsp valid=%0b required 1", rsp_valid_o);
    end else begin
      e = exp_q.pop_front();
      got = {rsp_write_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o};
      if (got !== e) begin
        fails++; $display("FAIL sw_rsp got %h required %h", got, e);
      end
    end
    if (ok) pop_rsp();
  endtask

  task automatic test_read_wait_states();
    apb_rsp_t e, got;
    bit ok;
    int pen = 0;
    ws = 3; rd_val = 32'h1234_5678;
    exp_xfer(1'b0, 16'h0020, 32'h0, 4'h0);
    exp_rsp(1'b0, 32'h1234_5678, 1'b0, 1'b0);
    push_cmd(1'b0, 16'h0020, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (penable_o) begin
        pen++;
        checks++;
        if (paddr_o !== 16'h0020 || pstrb_o !== 4'h0 || pwdata_o !== 32'h0) begin
          fails++;
          $display("FAIL rd_hold addr=%h strb=%h wdata=%h required 0020/0/0",
                   paddr_o, pstrb_o, pwdata_o);
        end
      end
      if (rsp_valid_o) break;
    end
    checks++;
    if (pen != 4) begin
      fails++; $display("FAIL rd_penable_cycles got %0d required 4", pen);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      fails++; $display("FAIL rd_rsp valid=%0b required 1", rsp_valid_o);
    end else begin
      e = exp_q.pop_front();
      got = {rsp_write_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o};
      if (got !== e) begin
        fails++; $display("FAIL rd_rsp got %h required %h", got, e);
      end
    end
    if (ok) pop_rsp();
    ws = 0; rd_val = 32'h5555_AAAA;
  endtask

  task automatic test_back_to_back();
    apb_rsp_t e, got;
    bit ok;
    int r0, m0;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    r0 = psel_rises; m0 = mon_cnt;
    for (int i = 0; i < 5; i++) begin
      a = 16'(16'h0100 + i * 4);
      d = 32'hA000_0000 + 32'(i);
      s = 4'(i * 3);
      exp_xfer(1'b1, a, d, s);
      exp_rsp(1'b1, 32'h0, 1'b0, 1'b0);
      push_cmd(1'b1, a, d, s);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (mon_cnt - m0 != 4) begin
      fails++; $display("FAIL b2b_xfers got %0d required 4", mon_cnt - m0);
    end
    checks++;
    if (psel_rises - r0 != 1) begin
      fails++; $display("FAIL b2b_psel_cont rises=%0d required 1", psel_rises - r0);
    end
    checks++;
    if ({cmd_ready_o, psel_o, rsp_valid_o} !== 3'b101) begin
      fails++;
      $display("FAIL b2b_stall rdy/psel/rv=%b required 101",
               {cmd_ready_o, psel_o, rsp_valid_o});
    end
    for (int k = 0; k < 5; k++) begin
      wait_rsp(ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        fails++; $display("FAIL b2b_rsp%0d valid=%0b required 1", k, rsp_valid_o);
      end else begin
        e = exp_q.pop_front();
        got = {rsp_write_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o};
        if (got !== e) begin
          fails++; $display("FAIL b2b_rsp%0d got %h required %h", k, got, e);
        end
      end
      if (ok) pop_rsp();
      if (k == 0) begin
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (mon_cnt - m0 != 5 || psel_rises - r0 != 2) begin
          fails++;
          $display("FAIL b2b_fifth xfers=%0d rises=%0d required 5/2",
                   mon_cnt - m0, psel_rises - r0);
        end
      end
    end
  endtask

  task automatic test_slverr();
    apb_rsp_t e, got;
    bit ok;
    ws = 1; err_val = 1'b1; rd_val = 32'hCAFE_F00D;
    exp_xfer(1'b0, 16'h0030, 32'h0, 4'h0);
    exp_rsp(1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
    push_cmd(1'b0, 16'h0030, 32'h0, 4'h0);
    wait_rsp(ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin
      fails++; $display("FAIL err_rsp valid=%0b required 1", rsp_valid_o);
    end else begin
      e = exp_q.pop_front();
      got = {rsp_write_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o};
      if (got !== e) begin
        fails++; $display("FAIL err_rsp got %h required %h", got, e);
      end
    end
    if (ok) pop_rsp();
    ws = 0; err_val = 1'b0; rd_val = 32'h5555_AAAA;
  endtask

  task automatic test_timeout();
    apb_rsp_t e, got;
    bit ok;
    int acc = 0;
    hang = 1'b1;
    exp_rsp(1'b0, 32'h0, 1'b1, 1'b1);
    push_cmd(1'b0, 16'h0040, 32'h0, 4'h0);
    exp_xfer(1'b1, 16'h0044, 32'h0BAD_CAFE, 4'h5);
    exp_rsp(1'b1, 32'h0, 1'b0, 1'b0);
    push_cmd(1'b1, 16'h0044, 32'h0BAD_CAFE, 4'h5);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (psel_o && penable_o) acc++;
      if (rsp_valid_o) break;
    end
    hang = 1'b0;
    checks++;
    if (acc != 8) begin
      fails++; $display("FAIL to_access_cycles got %0d required 8", acc);
    end
    checks++;
    if (psel_o !== 1'b0) begin
      fails++; $display("FAIL to_psel_drop psel=%0b required 0", psel_o);
    end
    for (int k = 0; k < 2; k++) begin
      wait_rsp(ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        fails++; $display("FAIL to_rsp%0d valid=%0b required 1", k, rsp_valid_o);
      end else begin
        e = exp_q.pop_front();
        got = {rsp_write_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o};
        if (got !== e) begin
          fails++; $display("FAIL to_rsp%0d got %h required %h", k, got, e);
        end
      end
      if (ok) pop_rsp();
    end
  endtask

  task automatic test_reset_mid();
    int seen_rsp = 0;
    int seen_psel = 0;
    hang = 1'b1;
    push_cmd(1'b1, 16'h0050, 32'h1111_1111, 4'hF);
    push_cmd(1'b1, 16'h0054, 32'h2222_2222, 4'hF);
    push_cmd(1'b0, 16'h0058, 32'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      if (penable_o) break;
      @(posedge clk); #1;
    end
    checks++;
    if (penable_o !== 1'b1) begin
      fails++; $display("FAIL rm_reached_access pen=%0b required 1", penable_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({psel_o, penable_o} !== 2'b00) begin
      fails++; $display("FAIL rm_async_drop psel/pen=%b required 00", {psel_o, penable_o});
    end
    @(posedge clk); #1;
    rst = 1'b0; hang = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({idle_o, cmd_ready_o, rsp_valid_o} !== 3'b110) begin
      fails++;
      $display("FAIL rm_idle idle/rdy/rv=%b required 110",
               {idle_o, cmd_ready_o, rsp_valid_o});
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid_o) seen_rsp++;
      if (psel_o) seen_psel++;
    end
    checks++;
    if (seen_rsp != 0 || seen_psel != 0) begin
      fails++;
      $display("FAIL rm_quiet rsp_cycles=%0d psel_cycles=%0d required 0/0",
               seen_rsp, seen_psel);
    end
  endtask

  task automatic test_apb_log();
    apb_cmd_t e, got;
    checks++;
    if (mon_q.size() != xq.size()) begin
      fails++;
      $display("FAIL log_count got %0d required %0d", mon_q.size(), xq.size());
    end
    while (mon_q.size() != 0 && xq.size() != 0) begin
      got = mon_q.pop_front();
      e = xq.pop_front();
      checks++;
      if (got !== e) begin
        fails++; $display("FAIL log_xfer got %h required %h", got, e);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL rsp_leftover got %0d required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
    cmd_wdata_i = '0; cmd_strb_i = '0; rsp_ready_i = 1'b0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait_states();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_apb_log();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
